// File: rtl/text_plane_scroll.sv
// text_plane_scroll: ROWS x COLS character-cell store driven by a cursor
// command port. Scrolling rotates a circular top-row pointer rather than
// moving data. The freed bottom row (or the whole plane, on CLEAR) is then
// blanked by a one-cell-per-cycle sweep. The renderer reads through a
// registered port in logical (screen) coordinates.
//
// Handshake: a command transfers on a rising clock edge where
// cmd_valid && cmd_ready. cmd_ready is high only while the store is idle.
// The source holds cmd_valid (with op/char) until the transfer. While busy,
// op/char are not looked at.

module text_plane_scroll #(
    parameter int                 ROWS   = 15,
    parameter int                 COLS   = 40,
    parameter int                 CHAR_W = 8,
    parameter int                 ROW_W  = 4,
    parameter int                 COL_W  = 6,
    parameter logic [CHAR_W-1:0]  BLANK  = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CHAR_W-1:0] cmd_char,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [CHAR_W-1:0] rd_data,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic              busy
);

    localparam int CELLS  = ROWS * COLS;
    localparam int ADDR_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

    // One bit wider than the index, so that ROWS == 2**ROW_W still compares correctly.
    localparam logic [ROW_W:0]    ROWS_X    = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0]    COLS_X    = (COL_W + 1)'(COLS);

    localparam logic [1:0] OP_PUT     = 2'd0;
    localparam logic [1:0] OP_NEWLINE = 2'd1;
    localparam logic [1:0] OP_CLEAR   = 2'd2;
    localparam logic [1:0] OP_HOME    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLR_ROW = 2'd1,
        S_CLR_ALL = 2'd2
    } state_t;

    state_t state;

    // Character storage. It has no reset; the CLR_ALL sweep after reset blanks it.
    logic [CHAR_W-1:0] mem [CELLS];

    logic [ROW_W-1:0]  top;        // physical row shown as logical row 0
    logic [ROW_W-1:0]  clr_row;    // physical row being blanked by CLR_ROW
    logic [COL_W-1:0]  clr_col;    // column sweep counter for CLR_ROW
    logic [ADDR_W-1:0] clr_addr;   // linear sweep counter for CLR_ALL

    logic              accept;
    logic              at_last_col;
    logic              at_last_row;
    logic              wrap;
    logic [ROW_W-1:0]  top_inc;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [CHAR_W-1:0] wdata;

    logic              rd_in_range;
    logic              rd_mask;
    logic [ADDR_W-1:0] rd_addr;

    // Logical-to-physical row: (lrow + t) mod ROWS. Both operands are below
    // ROWS, so one compare-and-subtract is enough.
    function automatic logic [ROW_W-1:0] to_phys(input logic [ROW_W-1:0] lrow,
                                                 input logic [ROW_W-1:0] t);
        logic [ROW_W:0] sum;
        sum = {1'b0, lrow} + {1'b0, t};
        if (sum >= ROWS_X) begin
            sum = sum - ROWS_X;
        end
        return sum[ROW_W-1:0];
    endfunction

    // Row-major linear address of a physical cell.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(prow) * COLS_A + ADDR_W'(col);
    endfunction

    assign cmd_ready   = (state == S_IDLE);
    assign busy        = ~cmd_ready;
    assign accept      = cmd_valid && cmd_ready;
    assign at_last_col = (cursor_col == LAST_COL);
    assign at_last_row = (cursor_row == LAST_ROW);
    // NEWLINE always wraps. PUT wraps only when it fills the last column.
    assign wrap        = (cmd_op == OP_NEWLINE) || at_last_col;
    assign top_inc     = (top == LAST_ROW) ? '0 : top + 1'b1;

    // Choose the single write: a PUT at the cursor, or the current sweep cell.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = BLANK;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    if (accept && (cmd_op == OP_PUT)) begin
                        we    = 1'b1;
                        waddr = cell_addr(to_phys(cursor_row, top), cursor_col);
                        wdata = cmd_char;
                    end
                end
                S_CLR_ROW: begin
                    we    = 1'b1;
                    waddr = cell_addr(clr_row, clr_col);
                end
                S_CLR_ALL: begin
                    we    = 1'b1;
                    waddr = clr_addr;
                end
                default: begin
                    we = 1'b0;
                end
            endcase
        end
    end

    // Memory write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Command FSM: cursor, scroll pointer and clear sweeps.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_CLR_ALL;
            clr_addr   <= '0;
            clr_col    <= '0;
            clr_row    <= '0;
            top        <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_PUT, OP_NEWLINE: begin
                                if (wrap) begin
                                    cursor_col <= '0;
                                    if (!at_last_row) begin
                                        cursor_row <= cursor_row + 1'b1;
                                    end else begin
                                        // Scroll: the old top row becomes the new bottom row.
                                        // The cursor stays on the bottom line.
                                        top     <= top_inc;
                                        clr_row <= top;
                                        clr_col <= '0;
                                        state   <= S_CLR_ROW;
                                    end
                                end else begin
                                    cursor_col <= cursor_col + 1'b1;
                                end
                            end
                            OP_CLEAR: begin
                                cursor_row <= '0;
                                cursor_col <= '0;
                                top        <= '0;
                                clr_addr   <= '0;
                                state      <= S_CLR_ALL;
                            end
                            OP_HOME: begin
                                cursor_row <= '0;
                                cursor_col <= '0;
                            end
                            default: begin
                                cursor_row <= cursor_row;
                            end
                        endcase
                    end
                end
                S_CLR_ROW: begin
                    if (clr_col == LAST_COL) begin
                        state <= S_IDLE;
                    end else begin
                        clr_col <= clr_col + 1'b1;
                    end
                end
                S_CLR_ALL: begin
                    if (clr_addr == LAST_ADDR) begin
                        state <= S_IDLE;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    state <= S_CLR_ALL;
                end
            endcase
        end
    end

    // Read address and masking. Cells still waiting to be blanked, and
    // coordinates off the screen, read as BLANK.
    always_comb begin
        rd_in_range = ({1'b0, rd_row} < ROWS_X) && ({1'b0, rd_col} < COLS_X);
        rd_mask     = !rd_in_range
                      || (state == S_CLR_ALL)
                      || ((state == S_CLR_ROW) && (rd_row == LAST_ROW));
        rd_addr     = '0;
        if (rd_in_range) begin
            rd_addr = cell_addr(to_phys(rd_row, top), rd_col);
        end
    end

    // Registered read port. A write in the same cycle is not visible until the next read.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= BLANK;
        end else if (rd_mask) begin
            rd_data <= BLANK;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_text_plane_scroll.sv
// Bench for text_plane_scroll. The reference screen is a plain 2-D array in
// logical coordinates. A scroll shifts its rows up and blanks the bottom
// line, and a clear blanks everything at once. Busy time is a countdown of
// cycles.

module tb_text_plane_scroll;

    localparam int ROWS   = 15;
    localparam int COLS   = 40;
    localparam int CHAR_W = 8;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 6;
    localparam int CELLS  = ROWS * COLS;
    localparam logic [CHAR_W-1:0] BLANK = 8'h00;

    localparam logic [1:0] OP_PUT     = 2'd0;
    localparam logic [1:0] OP_NEWLINE = 2'd1;
    localparam logic [1:0] OP_CLEAR   = 2'd2;
    localparam logic [1:0] OP_HOME    = 2'd3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [CHAR_W-1:0] cmd_char = '0;
    logic [ROW_W-1:0]  rd_row = '0;
    logic [COL_W-1:0]  rd_col = '0;
    logic [CHAR_W-1:0] rd_data;
    logic [ROW_W-1:0]  cursor_row;
    logic [COL_W-1:0]  cursor_col;
    logic              busy;

    text_plane_scroll #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .CHAR_W (CHAR_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .BLANK  (BLANK)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_char   (cmd_char),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    // Clock generation.
    always #5 clock = ~clock;

    // Reference model state.
    logic [CHAR_W-1:0] scr [ROWS][COLS];
    int                m_row;
    int                m_col;
    int                m_busy;
    bit                m_accepted;
    bit                rand_rd;

    // Scoreboard.
    logic [CHAR_W-1:0] exp_q[$];
    int                checks;
    int                failures;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_blank_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = BLANK;
    endtask

    task automatic model_scroll();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++)
            scr[ROWS-1][c] = BLANK;
        m_busy = COLS;
    endtask

    task automatic model_line_break();
        m_col = 0;
        if (m_row < ROWS - 1) m_row++;
        else model_scroll();
    endtask

    // One clock cycle: update the model at the edge, then compare all outputs.
    task automatic cycle();
        if (rand_rd) begin
            rd_row = 4'($urandom_range(0, 15));
            rd_col = 6'($urandom_range(0, 63));
        end
        @(posedge clock);
        if (reset || !(rd_row < ROWS && rd_col < COLS))
            exp_q.push_back(BLANK);
        else
            exp_q.push_back(scr[rd_row][rd_col]);
        m_accepted = 1'b0;
        if (reset) begin
            model_blank_all();
            m_row  = 0;
            m_col  = 0;
            m_busy = CELLS;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (cmd_valid) begin
            m_accepted = 1'b1;
            case (cmd_op)
                OP_PUT: begin
                    scr[m_row][m_col] = cmd_char;
                    if (m_col < COLS - 1) m_col++;
                    else model_line_break();
                end
                OP_NEWLINE: model_line_break();
                OP_CLEAR: begin
                    model_blank_all();
                    m_row  = 0;
                    m_col  = 0;
                    m_busy = CELLS;
                end
                default: begin
                    m_row = 0;
                    m_col = 0;
                end
            endcase
        end
        #1;
        check_val("rd_data", rd_data, exp_q.pop_front());
        check_val("cmd_ready", cmd_ready, m_busy == 0);
        check_val("busy", busy, m_busy != 0);
        check_val("cursor_row", cursor_row, m_row);
        check_val("cursor_col", cursor_col, m_col);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [CHAR_W-1:0] ch);
        bit done;
        done      = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_char  = ch;
        for (int n = 0; n < 2000; n++) begin
            cycle();
            if (m_accepted) begin
                done = 1'b1;
                break;
            end
        end
        check_val("cmd_accept", done, 1'b1);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 2000; n++) begin
            if (m_busy == 0) break;
            cycle();
        end
        check_val("wait_idle", m_busy, 0);
    endtask

    task automatic read_all();
        bit saved;
        saved   = rand_rd;
        rand_rd = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd_row = 4'(r);
                rd_col = 6'(c);
                cycle();
            end
        rand_rd = saved;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rand_rd  = 1'b0;
        m_row    = 0;
        m_col    = 0;
        m_busy   = CELLS;
        model_blank_all();

        // Reset, then the full power-up clear.
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (CELLS) cycle();
        read_all();

        // Single PUT with a same-cycle read of the same cell, then a next-cycle read.
        rd_row = '0;
        rd_col = '0;
        send_cmd(OP_PUT, 8'h41);
        cycle();

        // One full row of characters, back to back.
        send_cmd(OP_HOME, 8'h00);
        for (int i = 0; i < COLS; i++) send_cmd(OP_PUT, 8'(8'h30 + i));
        read_all();

        // Mark row 1 and row 14, then scroll once and later wrap top all the way round.
        send_cmd(OP_PUT, 8'h11);
        for (int i = 0; i < 13; i++) send_cmd(OP_NEWLINE, 8'h00);
        send_cmd(OP_PUT, 8'h22);
        send_cmd(OP_NEWLINE, 8'h00);
        wait_idle();
        read_all();
        for (int i = 0; i < ROWS; i++) begin
            send_cmd(OP_PUT, 8'(8'h60 + i));
            send_cmd(OP_NEWLINE, 8'h00);
        end
        wait_idle();
        read_all();

        // CLEAR with random reads during the sweep, then HOME leaves data intact.
        rand_rd = 1'b1;
        for (int i = 0; i < 50; i++) send_cmd(OP_PUT, 8'($urandom_range(1, 255)));
        send_cmd(OP_CLEAR, 8'h00);
        wait_idle();
        read_all();
        for (int i = 0; i < 25; i++) send_cmd(OP_PUT, 8'($urandom_range(1, 255)));
        send_cmd(OP_HOME, 8'h00);
        read_all();

        // Reset ten cycles into a row clear.
        for (int i = 0; i < ROWS; i++) send_cmd(OP_NEWLINE, 8'h00);
        repeat (10) cycle();
        pulse_reset();
        wait_idle();
        read_all();

        // Randomized command mix with random reads and idle gaps.
        rand_rd = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            int p;
            p = $urandom_range(0, 99);
            if (p < 78)      send_cmd(OP_PUT, 8'($urandom_range(1, 255)));
            else if (p < 90) send_cmd(OP_NEWLINE, 8'($urandom_range(0, 255)));
            else if (p < 95) send_cmd(OP_HOME, 8'($urandom_range(0, 255)));
            else if (p < 97) send_cmd(OP_CLEAR, 8'($urandom_range(0, 255)));
            else begin
                cmd_op   = 2'($urandom_range(0, 3));
                cmd_char = 8'($urandom_range(0, 255));
                repeat ($urandom_range(1, 5)) cycle();
            end
        end
        wait_idle();
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_plane_scroll.md
# text_plane_scroll

Parametrised character-cell store for the text display path. It sits between the terminal command source and the VGA glyph renderer. It holds a ROWS×COLS grid of character IDs behind a cursor-driven command port (put char, newline, clear, home), and scrolls in constant time through a circular top-row pointer instead of copying rows. The renderer reads through a registered port in logical (screen) coordinates.

## Interface
Parameters:
- ROWS, 15, number of text lines
- COLS, 40, characters per line
- CHAR_W, 8, character ID width
- ROW_W, 4, row index width, ≥ ceil(log2(ROWS))
- COL_W, 6, column index width, ≥ ceil(log2(COLS))
- BLANK, 0, character ID written by clear/scroll

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=PUT, 1=NEWLINE, 2=CLEAR, 3=HOME
- cmd_char  in  CHAR_W  character for PUT
- rd_row  in  ROW_W  logical read row
- rd_col  in  COL_W  read column
- rd_data  out  CHAR_W  registered read data
- cursor_row  out  ROW_W  logical cursor row
- cursor_col  out  COL_W  cursor column
- busy  out  1  clear sweep in progress (= !cmd_ready)

## Operation
- Storage: ROWS*COLS entries, single write port. Physical row = (logical row + top) mod ROWS. `top` ranges 0..ROWS-1 and wraps to 0.
- States: IDLE, CLR_ROW, CLR_ALL. A command is accepted on a posedge with cmd_valid && cmd_ready.
- PUT: write cmd_char at (cursor_row, cursor_col), then advance the cursor.
- Advance:
  - col<COLS-1: col+1.
  - Otherwise col=0 and: if row<ROWS-1, row+1; else scroll.
- NEWLINE: no write; col=0. Row rule and scroll rule are the same as the wrap case of advance.
- Scroll: the cursor row stays ROWS-1. top←top+1 mod ROWS. Enter CLR_ROW, which writes BLANK to every column of the new bottom row (the old physical `top` row), one column per cycle.
- CLEAR: cursor←(0,0), top←0, enter CLR_ALL, which writes BLANK to all ROWS*COLS entries, one per cycle, in address order.
- HOME: cursor←(0,0); no memory change; stays IDLE.
- Read masking:
  - During CLR_ALL, rd_data = BLANK.
  - During CLR_ROW, a read of logical row ROWS-1 returns BLANK.
  - Otherwise rd_data returns stored data.
- Out-of-range read (rd_row≥ROWS or rd_col≥COLS): rd_data = BLANK.
- cmd_op/cmd_char are ignored while busy. The source must hold cmd_valid until the command is accepted.

## Timing
- Reset: cursor (0,0), top 0, rd_data BLANK. State←CLR_ALL, so busy=1 and cmd_ready=0 for ROWS*COLS cycles after reset deasserts; the memory needs no reset of its own.
- Reset asserted mid-CLR_ROW or mid-CLR_ALL aborts the sweep and restarts a full CLR_ALL from address 0.
- Read latency 1: rd_data at edge N+1 reflects rd_row/rd_col sampled at edge N. A read issued in the same cycle as a write to the same cell returns old data; a read one cycle later returns new data.
- PUT write and cursor update both occur at the accepting edge; cursor outputs are registered.
- Scroll-causing command:
  - At the accepting edge, top and cursor update and state→CLR_ROW.
  - cmd_ready is low for exactly COLS cycles, then IDLE.
- CLEAR: cmd_ready is low for exactly ROWS*COLS cycles after the accepting edge.
- Back-to-back PUTs in IDLE: one per cycle, no bubbles.
- Arithmetic:
  - Physical address = phys_row*COLS + col, computed at width ceil(log2(ROWS*COLS)).
  - The modulo wrap is by compare-and-subtract, not by power-of-two masking.

## Test plan
- Reset, then poll: busy=1 for 600 cycles (defaults). Afterwards cmd_ready=1 and all 600 reads return 0x00.
- PUT 0x41 → next-cycle read of (0,0) gives 0x41; cursor (0,1). Same-cycle read of (0,0) gives 0x00.
- 40 PUTs of 0x30+i on row 0 → cursor (1,0); row 0 reads back 0x30..0x57. No busy cycles.
- Write 0x11 to row 1, 0x22 to row 14, then NEWLINE at row 14 → cmd_ready low 40 cycles; logical row 0 = 0x11, row 13 = 0x22, row 14 = 0x00; cursor (14,0); 15 further scrolls wrap top to 0 cleanly.
- CLEAR after text entry → rd_data 0x00 throughout 600 busy cycles; cursor (0,0); all cells 0 afterwards; HOME → cursor (0,0), data intact.
- Reset asserted 10 cycles into a CLR_ROW → full 600-cycle CLR_ALL restarts; cursor (0,0); no stale characters remain.
